// File: rtl/binary_maxpool_2x2.sv
// binary_maxpool_2x2: streams binary convolution result images from the
// result SRAM and writes a 2x2 stride-2 OR-pooled image list (header plus
// rows) to the pooled SRAM, under a run/busy handshake.
module binary_maxpool_2x2 (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  output logic        dut_busy,
  output logic [11:0] pool_sram_read_address,
  input  logic [15:0] sram_pool_read_data,
  output logic [11:0] pool_sram_write_address,
  output logic [15:0] pool_sram_write_data,
  output logic        pool_sram_write_enable
);

  // S_HDR and S_ROWS together form the streaming phase; no read bubbles
  // are inserted when moving between them.
  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_ROWS,
    S_FLUSH
  } state_t;

  state_t      state;
  logic        data_valid;   // read data holds a word of the list this cycle
  logic [3:0]  dim;          // current image width D
  logic [3:0]  rows_left;    // rows of the current image still to arrive
  logic        odd_row;      // next row is the second of a pair
  logic [15:0] held_row;     // first row of the current pair, already masked

  logic        header_legal;
  logic [15:0] row_mask;
  logic [15:0] row_masked;
  logic [15:0] pair_or;
  logic [15:0] pooled;

  // Header legality, row masking to D bits and horizontal OR of the row pair
  always_comb begin
    header_legal = (sram_pool_read_data == 16'd8)  ||
                   (sram_pool_read_data == 16'd10) ||
                   (sram_pool_read_data == 16'd14);
    row_mask = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < 32'(dim)) row_mask[i] = 1'b1;
    end
    row_masked = sram_pool_read_data & row_mask;
    pair_or    = held_row | row_masked;
    // Bits j >= P pick up only masked-off positions, so they come out 0.
    pooled = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      pooled[j] = pair_or[2*j] | pair_or[2*j+1];
    end
  end

  // Control FSM with registered SRAM addresses, write strobe and busy
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                   <= S_IDLE;
      data_valid              <= 1'b0;
      dim                     <= '0;
      rows_left               <= '0;
      odd_row                 <= 1'b0;
      held_row                <= '0;
      dut_busy                <= 1'b0;
      pool_sram_read_address  <= '0;
      pool_sram_write_address <= '0;
      pool_sram_write_data    <= '0;
      pool_sram_write_enable  <= 1'b0;
    end else begin
      pool_sram_write_enable <= 1'b0;
      if (pool_sram_write_enable)
        pool_sram_write_address <= pool_sram_write_address + 12'd1;

      case (state)
        S_IDLE: begin
          if (dut_run) begin
            state                   <= S_HDR;
            dut_busy                <= 1'b1;
            data_valid              <= 1'b0;
            pool_sram_read_address  <= '0;
            pool_sram_write_address <= '0;
          end
        end

        S_HDR, S_ROWS: begin
          data_valid             <= 1'b1;
          pool_sram_read_address <= pool_sram_read_address + 12'd1;
          if (data_valid) begin
            if (state == S_HDR) begin
              if (header_legal) begin
                dim                    <= sram_pool_read_data[3:0];
                rows_left              <= sram_pool_read_data[3:0];
                odd_row                <= 1'b0;
                pool_sram_write_data   <= {12'h000, sram_pool_read_data[4:1]};
                pool_sram_write_enable <= 1'b1;
                state                  <= S_ROWS;
              end else begin
                pool_sram_write_data   <= 16'h00FF;
                pool_sram_write_enable <= 1'b1;
                pool_sram_read_address <= pool_sram_read_address;
                state                  <= S_FLUSH;
              end
            end else begin
              rows_left <= rows_left - 4'd1;
              if (rows_left == 4'd1) state <= S_HDR;
              if (!odd_row) begin
                held_row <= row_masked;
              end else begin
                pool_sram_write_data   <= pooled;
                pool_sram_write_enable <= 1'b1;
              end
              odd_row <= ~odd_row;
            end
          end
        end

        S_FLUSH: begin
          state                  <= S_IDLE;
          dut_busy               <= 1'b0;
          pool_sram_read_address <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_maxpool_2x2.sv
// tb_binary_maxpool_2x2: directed checks of the binary 2x2 max-pool stage
// against hand-computed write tables and a small OR-pool reference model.
module tb_binary_maxpool_2x2;

  logic        clk;
  logic        reset_b;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] pool_sram_read_address;
  logic [15:0] sram_pool_read_data;
  logic [11:0] pool_sram_write_address;
  logic [15:0] pool_sram_write_data;
  logic        pool_sram_write_enable;

  binary_maxpool_2x2 dut (
    .clk                     (clk),
    .reset_b                 (reset_b),
    .dut_run                 (dut_run),
    .dut_busy                (dut_busy),
    .pool_sram_read_address  (pool_sram_read_address),
    .sram_pool_read_data     (sram_pool_read_data),
    .pool_sram_write_address (pool_sram_write_address),
    .pool_sram_write_data    (pool_sram_write_data),
    .pool_sram_write_enable  (pool_sram_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result SRAM with one cycle of read latency
  logic [15:0] mem [4096];
  always @(posedge clk) sram_pool_read_data <= mem[pool_sram_read_address];

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  busy_cycles;
  int  end_cyc;
  int  rd_bubbles;
  int  list_len;
  int  stray;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  function automatic logic [15:0] pool2(input int d, input logic [15:0] r0,
                                        input logic [15:0] r1);
    logic [15:0] res;
    res = '0;
    for (int j = 0; j < d / 2; j++)
      res[j] = r0[2*j] | r0[2*j+1] | r1[2*j] | r1[2*j+1];
    return res;
  endfunction

  // Reference walk of the list in mem; every write lands 3 cycles after
  // the cycle its triggering word address is presented.
  task automatic build_exp();
    int a;
    int w;
    int d;
    exp_q.delete();
    a = 0;
    w = 0;
    while (a < 4000) begin
      d = int'(mem[a]);
      if (d == 8 || d == 10 || d == 14) begin
        exp_q.push_back('{a + 3, 12'(w), 16'(d / 2)});
        w++;
        for (int r = 1; r < d; r += 2) begin
          exp_q.push_back('{a + 1 + r + 3, 12'(w), pool2(d, mem[a + r], mem[a + 1 + r])});
          w++;
        end
        a += d + 1;
      end else begin
        exp_q.push_back('{a + 3, 12'(w), 16'h00FF});
        list_len = a + 1;
        break;
      end
    end
  endtask

  // Start (unless already pending), then log writes, busy and read addresses
  task automatic run_list(input bit skip_start, input bit hold_run);
    got_q.delete();
    busy_cycles = 0;
    end_cyc     = -1;
    rd_bubbles  = 0;
    if (!skip_start) begin
      @(negedge clk);
      dut_run = 1'b1;
    end
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!hold_run) dut_run = 1'b0;
      if (pool_sram_write_enable)
        got_q.push_back('{c, pool_sram_write_address, pool_sram_write_data});
      if (c <= list_len + 1 && pool_sram_read_address !== 12'(c - 1)) rd_bubbles++;
      if (dut_busy) busy_cycles++;
      else begin
        end_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string name);
    check({name, "_nwrites"}, 0, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, "_wcyc"},  i, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
      check({name, "_waddr"}, i, 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check({name, "_wdata"}, i, 32'(got_q[i].data), 32'(exp_q[i].data));
    end
    check({name, "_busy_len"}, 0, 32'(busy_cycles), 32'(list_len + 2));
    check({name, "_busy_fall"}, 0, 32'(end_cyc), 32'(list_len + 3));
    check({name, "_rd_bubbles"}, 0, 32'(rd_bubbles), 32'd0);
  endtask

  task automatic load_t1();
    clear_mem();
    mem[0] = 16'd8;
    mem[2] = 16'h0081;
    mem[9] = 16'h00FF;
  endtask

  task automatic exp_t1();
    wr_t t1 [6];
    t1 = '{'{3,  12'd0, 16'h0004}, '{5,  12'd1, 16'h0009}, '{7, 12'd2, 16'h0000},
           '{9,  12'd3, 16'h0000}, '{11, 12'd4, 16'h0000}, '{12, 12'd5, 16'h00FF}};
    exp_q.delete();
    foreach (t1[i]) exp_q.push_back(t1[i]);
    list_len = 10;
  endtask

  initial begin
    reset_b = 1'b0;
    dut_run = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy",  0, 32'(dut_busy), 32'd0);
    check("rst_raddr", 0, 32'(pool_sram_read_address), 32'd0);
    check("rst_waddr", 0, 32'(pool_sram_write_address), 32'd0);
    check("rst_wdata", 0, 32'(pool_sram_write_data), 32'd0);
    check("rst_we",    0, 32'(pool_sram_write_enable), 32'd0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single D=8 image from the hand-computed table
    load_t1();
    exp_t1();
    run_list(1'b0, 1'b0);
    check_run("single_d8");

    // Back-to-back D=14, D=10, D=8 with random rows
    clear_mem();
    mem[0] = 16'd14;
    for (int i = 1; i <= 14; i++) mem[i] = 16'($urandom);
    mem[15] = 16'd10;
    for (int i = 16; i <= 25; i++) mem[i] = 16'($urandom);
    mem[26] = 16'd8;
    for (int i = 27; i <= 34; i++) mem[i] = 16'($urandom);
    mem[35] = 16'h00FF;
    build_exp();
    run_list(1'b0, 1'b0);
    check_run("list_14_10_8");
    check("list_len", 0, 32'(list_len), 32'd36);
    if (got_q.size() == 20) begin
      check("hdr14", 0,  32'(got_q[0].data),  32'd7);
      check("hdr10", 8,  32'(got_q[8].data),  32'd5);
      check("hdr8",  14, 32'(got_q[14].data), 32'd4);
      check("term",  19, 32'(got_q[19].data), 32'h00FF);
    end else begin
      check("list_nwrites_hand", 0, 32'(got_q.size()), 32'd20);
    end

    // Row bits at and above D must not leak into the pooled rows
    clear_mem();
    mem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) mem[i] = 16'hFC00;
    mem[11] = 16'h00FF;
    build_exp();
    run_list(1'b0, 1'b0);
    check_run("mask_d10");
    stray = 0;
    foreach (got_q[i]) if (i >= 1 && i <= 5 && got_q[i].data !== 16'h0000) stray++;
    check("mask_rows_zero", 0, 32'(stray), 32'd0);

    // Immediate terminator
    clear_mem();
    mem[0] = 16'h00FF;
    exp_q.delete();
    exp_q.push_back('{3, 12'd0, 16'h00FF});
    list_len = 1;
    run_list(1'b0, 1'b0);
    check_run("imm_term");

    // Illegal header 0x000C after a valid D=8 image
    clear_mem();
    mem[0] = 16'd8;
    for (int i = 1; i <= 8; i++) mem[i] = 16'($urandom);
    mem[9] = 16'h000C;
    mem[10] = 16'd8;
    build_exp();
    run_list(1'b0, 1'b0);
    check_run("illegal_hdr");
    if (got_q.size() > 0) begin
      check("illegal_last_addr", 0, 32'(got_q[got_q.size()-1].addr), 32'd5);
      check("illegal_last_data", 0, 32'(got_q[got_q.size()-1].data), 32'h00FF);
    end

    // dut_run held high: the second run restarts at address 0
    load_t1();
    exp_t1();
    run_list(1'b0, 1'b1);
    check_run("hold_run1");
    run_list(1'b1, 1'b0);
    check_run("hold_run2");

    // Reset pulsed mid-row aborts; a later run is unaffected
    @(negedge clk);
    dut_run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dut_run = 1'b0;
    repeat (5) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("abort_busy",  0, 32'(dut_busy), 32'd0);
    check("abort_raddr", 0, 32'(pool_sram_read_address), 32'd0);
    check("abort_waddr", 0, 32'(pool_sram_write_address), 32'd0);
    check("abort_wdata", 0, 32'(pool_sram_write_data), 32'd0);
    check("abort_we",    0, 32'(pool_sram_write_enable), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (pool_sram_write_enable || dut_busy) stray++;
    end
    check("abort_quiet", 0, 32'(stray), 32'd0);
    run_list(1'b0, 1'b0);
    check_run("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
